seg7_scan_driver: RTL

Time-multiplexed driver for a bank of common-anode/common-cathode seven-segment digits, replacing per-digit combinational decoders on the board I/O path. It latches a multi-digit value, decodes each 4-bit nibble as a hex glyph or as an instruction-mnemonic glyph, and scans the digits one at a time with a programmable refresh rate, dead time between digits, per-digit blanking and per-digit blinking. It sits between the processor's debug/status registers and the board's segment and anode pins.

---
 rtl/seg7_scan_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner: latches a multi-digit value and lights
// one digit per slot, with dead time, blanking, blinking and hex/mnemonic glyphs.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   mnem,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h3F;
         4'h1: hex_glyph = 7'h06;
         4'h2: hex_glyph = 7'h5B;
         4'h3: hex_glyph = 7'h4F;
         4'h4: hex_glyph = 7'h66;
         4'h5: hex_glyph = 7'h6D;
         4'h6: hex_glyph = 7'h7D;
         4'h7: hex_glyph = 7'h07;
         4'h8: hex_glyph = 7'h7F;
         4'h9: hex_glyph = 7'h6F;
         4'hA: hex_glyph = 7'h77;
         4'hB: hex_glyph = 7'h7C;
         4'hC: hex_glyph = 7'h39;
         4'hD: hex_glyph = 7'h5E;
         4'hE: hex_glyph = 7'h79;
         default: hex_glyph = 7'h71;
      endcase
   endfunction

   // Codes past BX have no mnemonic and show a dash.
   function automatic logic [6:0] mnem_glyph(input logic [3:0] n);
      case (n)
         4'h0: mnem_glyph = 7'h37;
         4'h1: mnem_glyph = 7'h77;
         4'h2: mnem_glyph = 7'h3E;
         4'h3: mnem_glyph = 7'h54;
         4'h4: mnem_glyph = 7'h3F;
         4'h5: mnem_glyph = 7'h39;
         4'h6: mnem_glyph = 7'h1C;
         4'h7: mnem_glyph = 7'h38;
         4'h8: mnem_glyph = 7'h6D;
         4'h9: mnem_glyph = 7'h7C;
         4'hA: mnem_glyph = 7'h76;
         default: mnem_glyph = 7'h40;
      endcase
   endfunction

   logic [NUM_DIGITS-1:0][3:0] sh_value;
   logic [NUM_DIGITS-1:0]      sh_mnem, sh_blank, sh_blink;
   logic [CW-1:0]              cnt;
   logic [IW-1:0]              idx;
   logic [FW-1:0]              frm;
   logic                       phase;

   logic                  slot_end, wrap, lit;
   logic [3:0]            nib;
   logic [6:0]            glyph, seg_ah;
   logic [NUM_DIGITS-1:0] an_ah;

   assign slot_end = (cnt == CNT_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);

   always_comb begin
      nib    = sh_value[idx];
      glyph  = sh_mnem[idx] ? mnem_glyph(nib) : hex_glyph(nib);
      lit    = (cnt != '0) && !sh_blank[idx] && !(sh_blink[idx] && phase);
      seg_ah = lit ? glyph : 7'h00;
      an_ah  = lit ? (NUM_DIGITS'(1) << idx) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_value   <= '0;
         sh_mnem    <= '0;
         sh_blank   <= '0;
         sh_blink   <= '0;
         cnt        <= '0;
         idx        <= '0;
         frm        <= '0;
         phase      <= 1'b0;
         seg        <= {7{ACTIVE_LOW}};
         an         <= {NUM_DIGITS{ACTIVE_LOW}};
         frame_tick <= 1'b0;
      end else begin
         if (load) begin
            sh_value <= value;
            sh_mnem  <= mnem;
            sh_blank <= blank;
            sh_blink <= blink;
         end
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (wrap) begin
            if (frm == FRM_LAST) begin
               frm   <= '0;
               phase <= ~phase;
            end else begin
               frm <= frm + 1'b1;
            end
         end
         // Outputs reflect this cycle's scan state, so they lag it by one cycle.
         seg        <= seg_ah ^ {7{ACTIVE_LOW}};
         an         <= an_ah ^ {NUM_DIGITS{ACTIVE_LOW}};
         frame_tick <= wrap;
      end
   end

endmodule
